// File: rtl/alu_pkg.sv
// Shared constants, state encoding and small helpers for the alu_exec block.
// Flag indices follow the x86 FLAGS layout.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADC = 3'd2;
  localparam logic [2:0] ALU_SBB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDMEM = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRMEM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_P = 2;
  localparam int FLAG_A = 4;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;
  localparam int FLAG_O = 11;

  localparam logic [11:0] FLAGS_RESET = 12'h002;

  function automatic logic [2:0] byte_count(input logic isize, input logic opsize);
    if (!isize) begin
      return 3'd1;
    end else if (!opsize) begin
      return 3'd2;
    end else begin
      return 3'd4;
    end
  endfunction

  function automatic logic [31:0] size_mask(input logic isize, input logic opsize);
    if (!isize) begin
      return 32'h0000_00FF;
    end else if (!opsize) begin
      return 32'h0000_FFFF;
    end else begin
      return 32'hFFFF_FFFF;
    end
  endfunction

  function automatic logic msb_of(input logic [31:0] v, input logic isize, input logic opsize);
    if (!isize) begin
      return v[7];
    end else if (!opsize) begin
      return v[15];
    end else begin
      return v[31];
    end
  endfunction

  // PF is set when the low result byte has an even number of ones
  function automatic logic even_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/alu_exec_alu.sv
// Combinational ALU: result and x86-style flags for 8/16/32-bit operands.
module alu_exec_alu
  import alu_pkg::*;
(
  input  logic        isize,
  input  logic        opsize,
  input  logic [2:0]  alumode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [11:0] flags_in,
  output logic [31:0] result,
  output logic [11:0] flags_out
);

  logic [31:0] mask_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] r_s;
  logic        cin_add_s;
  logic        cin_sub_s;
  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic        cf_s;
  logic        of_s;
  logic        af_s;

  // Operands are masked to the active width so the 33-bit borrow lands in bit 32
  always_comb begin
    mask_s    = size_mask(isize, opsize);
    a_s       = op1 & mask_s;
    b_s       = op2 & mask_s;
    cin_add_s = (alumode == ALU_ADC) ? flags_in[FLAG_C] : 1'b0;
    cin_sub_s = (alumode == ALU_SBB) ? flags_in[FLAG_C] : 1'b0;
    sum_s     = {1'b0, a_s} + {1'b0, b_s} + {32'd0, cin_add_s};
    diff_s    = {1'b0, a_s} - {1'b0, b_s} - {32'd0, cin_sub_s};
    r_s       = 32'd0;
    cf_s      = 1'b0;
    of_s      = 1'b0;
    af_s      = 1'b0;
    case (alumode)
      ALU_ADD, ALU_ADC: begin
        r_s  = sum_s[31:0] & mask_s;
        if (!isize) begin
          cf_s = sum_s[8];
        end else if (!opsize) begin
          cf_s = sum_s[16];
        end else begin
          cf_s = sum_s[32];
        end
        of_s = (msb_of(a_s, isize, opsize) == msb_of(b_s, isize, opsize)) &&
               (msb_of(r_s, isize, opsize) != msb_of(a_s, isize, opsize));
        af_s = a_s[4] ^ b_s[4] ^ r_s[4];
      end
      ALU_SUB, ALU_SBB, ALU_CMP: begin
        r_s  = diff_s[31:0] & mask_s;
        cf_s = diff_s[32];
        of_s = (msb_of(a_s, isize, opsize) != msb_of(b_s, isize, opsize)) &&
               (msb_of(r_s, isize, opsize) != msb_of(a_s, isize, opsize));
        af_s = a_s[4] ^ b_s[4] ^ r_s[4];
      end
      ALU_OR:  r_s = a_s | b_s;
      ALU_AND: r_s = a_s & b_s;
      ALU_XOR: r_s = a_s ^ b_s;
      default: r_s = 32'd0;
    endcase

    result            = r_s;
    flags_out         = flags_in;
    flags_out[FLAG_C] = cf_s;
    flags_out[FLAG_P] = even_parity(r_s[7:0]);
    flags_out[FLAG_A] = af_s;
    flags_out[FLAG_Z] = (r_s == 32'd0);
    flags_out[FLAG_S] = msb_of(r_s, isize, opsize);
    flags_out[FLAG_O] = of_s;
    flags_out[1]      = 1'b1;
    flags_out[3]      = 1'b0;
    flags_out[5]      = 1'b0;
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU executor: optional byte-serial memory read of the rm operand,
// one ALU step, optional byte-serial write-back, then a one-cycle completion pulse.
module alu_exec
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  alumode,
  input  logic        isize,
  input  logic        opsize,
  input  logic        dir,
  input  logic        rm_mem,
  input  logic [31:0] ea,
  input  logic [31:0] op_reg,
  input  logic [31:0] op_rm,
  input  logic [11:0] flags_i,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        wb_reg,
  output logic        wb_rm,
  output logic [31:0] wb_data,
  output logic [11:0] flags_o,
  output logic        flags_we
);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [2:0]  alumode_r;
  logic        isize_r;
  logic        opsize_r;
  logic        dir_r;
  logic        rm_mem_r;
  logic [31:0] ea_r;
  logic [31:0] reg_r;
  logic [31:0] rm_r;
  logic [11:0] flags_in_r;

  logic [31:0] op1_s;
  logic [31:0] op2_s;
  logic [31:0] alu_result_s;
  logic [11:0] alu_flags_s;
  logic [2:0]  cnt_next_s;
  logic        last_s;
  logic        is_cmp_s;

  // Operand routing: dir selects which side is the destination
  always_comb begin
    if (dir_r) begin
      op1_s = reg_r;
      op2_s = rm_r;
    end else begin
      op1_s = rm_r;
      op2_s = reg_r;
    end
    cnt_next_s = cnt_r + 3'd1;
    last_s     = (cnt_r == (byte_count(isize_r, opsize_r) - 3'd1));
    is_cmp_s   = (alumode_r == ALU_CMP);
  end

  alu_exec_alu u_alu (
    .isize     (isize_r),
    .opsize    (opsize_r),
    .alumode   (alumode_r),
    .op1       (op1_s),
    .op2       (op2_s),
    .flags_in  (flags_in_r),
    .result    (alu_result_s),
    .flags_out (alu_flags_s)
  );

  // Control FSM with all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      alumode_r  <= 3'd0;
      isize_r    <= 1'b0;
      opsize_r   <= 1'b0;
      dir_r      <= 1'b0;
      rm_mem_r   <= 1'b0;
      ea_r       <= 32'd0;
      reg_r      <= 32'd0;
      rm_r       <= 32'd0;
      flags_in_r <= 12'd0;
      mem_addr   <= 32'd0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_reg     <= 1'b0;
      wb_rm      <= 1'b0;
      wb_data    <= 32'd0;
      flags_o    <= FLAGS_RESET;
      flags_we   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            alumode_r  <= alumode;
            isize_r    <= isize;
            opsize_r   <= opsize;
            dir_r      <= dir;
            rm_mem_r   <= rm_mem;
            ea_r       <= ea;
            reg_r      <= op_reg;
            flags_in_r <= flags_i;
            cnt_r      <= 3'd0;
            busy       <= 1'b1;
            if (rm_mem) begin
              rm_r     <= 32'd0;
              mem_rd   <= 1'b1;
              mem_addr <= ea;
              state_r  <= ST_RDMEM;
            end else begin
              rm_r    <= op_rm;
              state_r <= ST_EXEC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RDMEM: begin
          if (mem_ready) begin
            rm_r[{cnt_r[1:0], 3'b000} +: 8] <= mem_rdata;
            if (last_s) begin
              cnt_r   <= 3'd0;
              mem_rd  <= 1'b0;
              state_r <= ST_EXEC;
            end else begin
              cnt_r    <= cnt_next_s;
              mem_addr <= ea_r + {29'd0, cnt_next_s};
            end
          end else begin
            state_r <= ST_RDMEM;
          end
        end
        ST_EXEC: begin
          wb_data <= alu_result_s;
          flags_o <= alu_flags_s;
          if (!dir_r && rm_mem_r && !is_cmp_s) begin
            cnt_r     <= 3'd0;
            mem_we    <= 1'b1;
            mem_addr  <= ea_r;
            mem_wdata <= alu_result_s[7:0];
            state_r   <= ST_WRMEM;
          end else begin
            done     <= 1'b1;
            flags_we <= 1'b1;
            wb_reg   <= dir_r && !is_cmp_s;
            wb_rm    <= !dir_r && !rm_mem_r && !is_cmp_s;
            state_r  <= ST_DONE;
          end
        end
        ST_WRMEM: begin
          if (mem_ready) begin
            if (last_s) begin
              cnt_r    <= 3'd0;
              mem_we   <= 1'b0;
              done     <= 1'b1;
              flags_we <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              cnt_r     <= cnt_next_s;
              mem_addr  <= ea_r + {29'd0, cnt_next_s};
              mem_wdata <= wb_data[{cnt_next_s[1:0], 3'b000} +: 8];
            end
          end else begin
            state_r <= ST_WRMEM;
          end
        end
        ST_DONE: begin
          done     <= 1'b0;
          flags_we <= 1'b0;
          wb_reg   <= 1'b0;
          wb_rm    <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          cnt_r    <= 3'd0;
          mem_rd   <= 1'b0;
          mem_we   <= 1'b0;
          done     <= 1'b0;
          flags_we <= 1'b0;
          wb_reg   <= 1'b0;
          wb_rm    <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clock  in  1  single system clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin one ALU operation, sampled only in IDLE.
REQ-005 alumode  in  3  0 ADD, 1 OR, 2 ADC, 3 SBB, 4 AND, 5 SUB, 6 XOR, 7 CMP.
REQ-006 isize  in  1  0 = byte, 1 = word/dword.
REQ-007 opsize  in  1  with isize=1: 0 = 16-bit, 1 = 32-bit.
REQ-008 dir  in  1  0: dest = rm, src = reg; 1: dest = reg, src = rm.
REQ-009 rm_mem  in  1  1 = rm operand in memory at ea; 0 = rm operand is op_rm.
REQ-010 ea  in  32  effective address of memory operand.
REQ-011 op_reg  in  32  reg-field operand value.
REQ-012 op_rm  in  32  rm register value, used when rm_mem=0.
REQ-013 flags_i  in  12  current flags {O,D,I,T,S,Z,0,A,0,P,1,C}.
REQ-014 mem_addr  out  32  byte address; mem_rd  out  1; mem_we  out  1; mem_wdata  out  8.
REQ-015 mem_rdata  in  8  read byte; mem_ready  in  1  completes current byte access.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 wb_reg  out  1  and wb_rm  out  1  register writeback strobes; wb_data  out  32  result, zero-extended.
REQ-019 flags_o  out  12  new flags; flags_we  out  1  flags write strobe.

Function
REQ-020 States SHALL be IDLE, RDMEM, EXEC, WRMEM, DONE.
REQ-021 IDLE with start=1 SHALL latch all operand inputs and go to RDMEM if rm_mem=1, else EXEC; start in any other state SHALL be ignored.
REQ-022 Byte count N SHALL be 1 (isize=0), 2 (isize=1, opsize=0), 4 (isize=1, opsize=1).
REQ-023 RDMEM SHALL hold mem_rd=1, mem_addr=ea+cnt (32-bit modular wrap), capture mem_rdata into byte cnt on mem_ready, and increment cnt; after byte N-1 it SHALL go to EXEC.
REQ-024 While mem_ready=0 the address and strobes SHALL stay stable.
REQ-025 op1 SHALL be the destination operand, op2 the source; upper unused bits SHALL be ignored.
REQ-026 EXEC SHALL register the alu result and flags.
REQ-027 EXEC SHALL go to WRMEM if dir=0, rm_mem=1 and alumode≠7; otherwise it SHALL go to DONE.
REQ-028 WRMEM SHALL write result bytes little-endian, low byte first, with mem_we=1, mem_addr=ea+cnt and one byte per mem_ready, then go to DONE.
REQ-029 DONE SHALL pulse done and flags_we for one cycle and return to IDLE.
REQ-030 DONE SHALL pulse wb_reg if dir=1, or wb_rm if dir=0 and rm_mem=0; for alumode 7 (CMP) it SHALL pulse neither.
REQ-031 Register-only latency: start accepted in cycle 0 SHALL give done in cycle 2; each memory byte SHALL add ≥1 cycle.
REQ-032 mem_rd and mem_we SHALL never be high together.
REQ-033 The next start SHALL be accepted in the cycle after DONE.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE and cnt=0.
REQ-035 During reset, all outputs SHALL be 0, including mem_rd, mem_we, done, busy, wb_* and flags_we.
REQ-036 flags_o SHALL reset to 12'h002.
REQ-037 Reset mid-operation SHALL abandon the operation with no done pulse and no further memory access.

Structure
REQ-038 Package alu_pkg SHALL hold the alumode constants, the state encoding and the flag bit indices (C=0, P=2, A=4, Z=6, S=7, O=11).
REQ-039 The block SHALL instantiate one sub-module: the core's combinational alu (isize, opsize, alumode, op1, op2, flags -> result, flags).

Verification
REQ-040 ADD byte, dir=1, op_reg=7F, op_rm=01 -> done in cycle 2, wb_reg=1, wb_data=00000080, O=1 S=1 Z=0 A=1 C=0.
REQ-041 SUB dword, dir=0, rm_mem=1, ea=1000, memory 00000000, op_reg=1 -> 4 reads at 1000..1003, then 4 writes of FF, S=1 C=1, wb strobes 0.
REQ-042 CMP word in memory, equal operands 1234 -> 2 reads, no writes, flags_we=1, Z=1, no wb strobe.
REQ-043 ea=FFFFFFFE, dword read -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-044 mem_ready held low 3 cycles during WRMEM, then reset_n pulsed low -> address stable while stalled; on reset mem_we=0 and busy=0 at once, no done.
REQ-045 start re-asserted while busy -> ignored; exactly one done pulse.
